// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter and sequencer for the data_memory port; one strobe per transaction.
// Optional build macro DMEM_ARB_LOCK_EN adds per-master lock inputs for atomic sequences.
module dmem_arbiter #(
    parameter int WAIT_STATES = 0,
    parameter int WS_BITS     = 4
) (
    input  logic        clock,
    input  logic        reset,
`ifdef DMEM_ARB_LOCK_EN
    input  logic        m0_lock_in,
    input  logic        m1_lock_in,
`endif
    input  logic        m0_req_in,
    input  logic [31:0] m0_addr_in,
    input  logic [31:0] m0_wdata_in,
    input  logic        m0_we_in,
    input  logic [1:0]  m0_size_in,
    output logic        m0_ack_out,
    output logic [31:0] m0_rdata_out,
    input  logic        m1_req_in,
    input  logic [31:0] m1_addr_in,
    input  logic [31:0] m1_wdata_in,
    input  logic        m1_we_in,
    input  logic [1:0]  m1_size_in,
    output logic        m1_ack_out,
    output logic [31:0] m1_rdata_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_wdata_out,
    output logic [1:0]  mem_size_out,
    output logic        mem_re_out,
    output logic        mem_we_out,
    input  logic [31:0] mem_rdata_in,
    output logic        busy_out,
    output logic        grant_out
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    localparam logic [WS_BITS-1:0] WS_LOAD = WS_BITS'(WAIT_STATES);

    state_t             state, state_nxt;
    logic [WS_BITS-1:0] ws_cnt;
    logic               last_grant;
    logic               grant_en, grant_sel, strobe;
    logic [1:0]         req_vec;
    logic [31:0]        req_addr, req_wdata;
    logic               req_we;
    logic [1:0]         req_size;
    logic               lock_hold, lock_take, lock_owner;

    assign req_vec = {m1_req_in, m0_req_in};

`ifdef DMEM_ARB_LOCK_EN
    logic       locked, owner, lock_release;
    logic [1:0] lock_vec;

    assign lock_vec     = {m1_lock_in, m0_lock_in};
    assign lock_release = locked && (state == IDLE) && !lock_vec[owner];
    assign lock_hold    = locked && !lock_release;
    assign lock_take    = (state == RESP) && lock_vec[grant_out];
    assign lock_owner   = lock_take ? grant_out : owner;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            locked <= 1'b0;
            owner  <= 1'b0;
        end else if (lock_take) begin
            locked <= 1'b1;
            owner  <= grant_out;
        end else if (lock_release) begin
            locked <= 1'b0;
        end
    end
`else
    assign lock_hold  = 1'b0;
    assign lock_take  = 1'b0;
    assign lock_owner = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        grant_sel = last_grant;
        strobe    = 1'b0;
        unique case (state)
            IDLE: begin
                if (lock_hold) begin
                    grant_en  = req_vec[lock_owner];
                    grant_sel = lock_owner;
                end else if (m0_req_in && m1_req_in) begin
                    grant_en  = 1'b1;
                    grant_sel = ~last_grant;
                end else if (m0_req_in) begin
                    grant_en  = 1'b1;
                    grant_sel = 1'b0;
                end else if (m1_req_in) begin
                    grant_en  = 1'b1;
                    grant_sel = 1'b1;
                end
                if (grant_en) state_nxt = ACCESS;
            end
            ACCESS: begin
                if (ws_cnt == '0) begin
                    strobe    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                // the acked master still holds its old req here, so only the other one may win
                grant_sel = ~grant_out;
                grant_en  = req_vec[grant_sel] &&
                            (!(lock_hold || lock_take) || (lock_owner == grant_sel));
                state_nxt = grant_en ? ACCESS : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ws_cnt       <= '0;
            last_grant   <= 1'b1;
            grant_out    <= 1'b0;
            req_addr     <= '0;
            req_wdata    <= '0;
            req_we       <= 1'b0;
            req_size     <= '0;
            m0_ack_out   <= 1'b0;
            m1_ack_out   <= 1'b0;
            m0_rdata_out <= '0;
            m1_rdata_out <= '0;
        end else begin
            state      <= state_nxt;
            m0_ack_out <= strobe && !grant_out;
            m1_ack_out <= strobe && grant_out;
            if (strobe) begin
                if (grant_out) m1_rdata_out <= req_we ? 32'h0 : mem_rdata_in;
                else           m0_rdata_out <= req_we ? 32'h0 : mem_rdata_in;
            end
            if (grant_en) begin
                grant_out  <= grant_sel;
                last_grant <= grant_sel;
                ws_cnt     <= WS_LOAD;
                req_addr   <= grant_sel ? m1_addr_in  : m0_addr_in;
                req_wdata  <= grant_sel ? m1_wdata_in : m0_wdata_in;
                req_we     <= grant_sel ? m1_we_in    : m0_we_in;
                req_size   <= grant_sel ? m1_size_in  : m0_size_in;
            end else if (state == ACCESS && ws_cnt != '0) begin
                ws_cnt <= ws_cnt - WS_BITS'(1);
            end
        end
    end

    // strobes decode from state flops only, so reset cuts them off immediately
    assign mem_addr_out  = req_addr;
    assign mem_wdata_out = req_wdata;
    assign mem_size_out  = req_size;
    assign mem_re_out    = strobe && !req_we;
    assign mem_we_out    = strobe && req_we;
    assign busy_out      = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (0 and 3 wait states) on shared requester inputs,
// checked against transaction-level latency/round-robin rules and a behavioural memory.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    always #5 clock = ~clock;

    logic        m0_req, m1_req, m0_we, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [1:0]  m0_size, m1_size;
`ifdef DMEM_ARB_LOCK_EN
    logic        m0_lock, m1_lock;
`endif

    logic        a_m0_ack, a_m1_ack, a_mem_re, a_mem_we, a_busy, a_grant;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [1:0]  a_mem_size;
    logic        b_m0_ack, b_m1_ack, b_mem_re, b_mem_we, b_busy, b_grant;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [1:0]  b_mem_size;

    function automatic logic [31:0] mem_model(input logic [31:0] addr);
        if (addr == 32'h1000_0010) return 32'hDEAD_BEEF;
        return {addr[15:0], addr[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    assign a_mem_rdata = mem_model(a_mem_addr);
    assign b_mem_rdata = mem_model(b_mem_addr);

    dmem_arbiter #(.WAIT_STATES(0), .WS_BITS(4)) u_ws0 (
        .clock(clock), .reset(reset),
`ifdef DMEM_ARB_LOCK_EN
        .m0_lock_in(m0_lock), .m1_lock_in(m1_lock),
`endif
        .m0_req_in(m0_req), .m0_addr_in(m0_addr), .m0_wdata_in(m0_wdata), .m0_we_in(m0_we),
        .m0_size_in(m0_size), .m0_ack_out(a_m0_ack), .m0_rdata_out(a_m0_rdata),
        .m1_req_in(m1_req), .m1_addr_in(m1_addr), .m1_wdata_in(m1_wdata), .m1_we_in(m1_we),
        .m1_size_in(m1_size), .m1_ack_out(a_m1_ack), .m1_rdata_out(a_m1_rdata),
        .mem_addr_out(a_mem_addr), .mem_wdata_out(a_mem_wdata), .mem_size_out(a_mem_size),
        .mem_re_out(a_mem_re), .mem_we_out(a_mem_we), .mem_rdata_in(a_mem_rdata),
        .busy_out(a_busy), .grant_out(a_grant)
    );

    dmem_arbiter #(.WAIT_STATES(3), .WS_BITS(4)) u_ws3 (
        .clock(clock), .reset(reset),
`ifdef DMEM_ARB_LOCK_EN
        .m0_lock_in(m0_lock), .m1_lock_in(m1_lock),
`endif
        .m0_req_in(m0_req), .m0_addr_in(m0_addr), .m0_wdata_in(m0_wdata), .m0_we_in(m0_we),
        .m0_size_in(m0_size), .m0_ack_out(b_m0_ack), .m0_rdata_out(b_m0_rdata),
        .m1_req_in(m1_req), .m1_addr_in(m1_addr), .m1_wdata_in(m1_wdata), .m1_we_in(m1_we),
        .m1_size_in(m1_size), .m1_ack_out(b_m1_ack), .m1_rdata_out(b_m1_rdata),
        .mem_addr_out(b_mem_addr), .mem_wdata_out(b_mem_wdata), .mem_size_out(b_mem_size),
        .mem_re_out(b_mem_re), .mem_we_out(b_mem_we), .mem_rdata_in(b_mem_rdata),
        .busy_out(b_busy), .grant_out(b_grant)
    );

    // observed instance selected per test
    bit          mon_inst = 1'b0;
    logic        o_re, o_we, o_ack0, o_ack1, o_grant;
    logic [31:0] o_addr, o_wdata, o_rd0, o_rd1;
    assign o_re    = mon_inst ? b_mem_re    : a_mem_re;
    assign o_we    = mon_inst ? b_mem_we    : a_mem_we;
    assign o_ack0  = mon_inst ? b_m0_ack    : a_m0_ack;
    assign o_ack1  = mon_inst ? b_m1_ack    : a_m1_ack;
    assign o_grant = mon_inst ? b_grant     : a_grant;
    assign o_addr  = mon_inst ? b_mem_addr  : a_mem_addr;
    assign o_wdata = mon_inst ? b_mem_wdata : a_mem_wdata;
    assign o_rd0   = mon_inst ? b_m0_rdata  : a_m0_rdata;
    assign o_rd1   = mon_inst ? b_m1_rdata  : a_m1_rdata;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        logic        m;
    } ev_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [1:0]  size;
    } txn_t;

    ev_t  strb[$];
    ev_t  acks[$];
    txn_t q0[$];
    txn_t q1[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset) begin
            if (o_re || o_we) strb.push_back('{cyc, o_addr, o_wdata, o_we, o_grant});
            if (o_ack0) acks.push_back('{cyc, 32'h0, o_rd0, 1'b0, 1'b0});
            if (o_ack1) acks.push_back('{cyc, 32'h0, o_rd1, 1'b0, 1'b1});
        end
    end

    task automatic present();
        if (q0.size() > 0) begin
            m0_req = 1'b1; m0_addr = q0[0].addr; m0_wdata = q0[0].wdata;
            m0_we = q0[0].we; m0_size = q0[0].size;
        end else m0_req = 1'b0;
        if (q1.size() > 0) begin
            m1_req = 1'b1; m1_addr = q1[0].addr; m1_wdata = q1[0].wdata;
            m1_we = q1[0].we; m1_size = q1[0].size;
        end else m1_req = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
        if (q1.size() == 0) m1_lock = 1'b0;
`endif
    endtask

    // requesters hold req until ack, then present their next queued transaction
    task automatic run(input int ncyc);
        present();
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clock); #1;
            if (o_ack0 && q0.size() > 0) void'(q0.pop_front());
            if (o_ack1 && q1.size() > 0) void'(q1.pop_front());
            present();
        end
    endtask

    task automatic do_reset(input bit inst);
        @(posedge clock); #1;
        reset = 1'b0;
        q0.delete(); q1.delete();
        present();
`ifdef DMEM_ARB_LOCK_EN
        m0_lock = 1'b0; m1_lock = 1'b0;
`endif
        mon_inst = inst;
        @(posedge clock); #1;
        reset = 1'b1;
        strb.delete(); acks.delete();
    endtask

    task automatic test_reset();
        do_reset(0);
        q0.push_back('{32'h0000_0040, 32'h0, 1'b0, 2'b11});
        run(4);
        @(posedge clock); #3;
        reset = 1'b0;
        #1;
        vectors++;
        if ({a_m0_ack, a_m1_ack, a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata, a_mem_size,
             a_mem_re, a_mem_we, a_busy, a_grant} !== '0) begin
            miscompares++;
            $display("FAIL reset_ws0 outputs not zero: addr=%h rd0=%h busy=%b grant=%b",
                     a_mem_addr, a_m0_rdata, a_busy, a_grant);
        end
        vectors++;
        if ({b_m0_ack, b_m1_ack, b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata, b_mem_size,
             b_mem_re, b_mem_we, b_busy, b_grant} !== '0) begin
            miscompares++;
            $display("FAIL reset_ws3 outputs not zero: addr=%h rd0=%h busy=%b grant=%b",
                     b_mem_addr, b_m0_rdata, b_busy, b_grant);
        end
    endtask

    task automatic test_single_read();
        int c0;
        do_reset(0);
        q0.push_back('{32'h1000_0010, 32'h0, 1'b0, 2'b11});
        c0 = cyc;
        run(6);
        vectors++;
        if (strb.size() !== 1) begin miscompares++; $display("FAIL single_strobe_count got %0d exp 1", strb.size()); end
        if (strb.size() > 0) begin
            vectors++;
            if (strb[0].cyc !== c0 + 1 || strb[0].we !== 1'b0 || strb[0].addr !== 32'h1000_0010) begin
                miscompares++;
                $display("FAIL single_strobe got cyc %0d we %b addr %h exp cyc %0d we 0 addr 10000010",
                         strb[0].cyc - c0, strb[0].we, strb[0].addr, 1);
            end
        end
        vectors++;
        if (acks.size() !== 1) begin miscompares++; $display("FAIL single_ack_count got %0d exp 1", acks.size()); end
        if (acks.size() > 0) begin
            vectors++;
            if (acks[0].m !== 1'b0 || acks[0].cyc !== c0 + 2) begin
                miscompares++;
                $display("FAIL single_ack got m%0d at %0d exp m0 at 2", acks[0].m, acks[0].cyc - c0);
            end
            vectors++;
            if (acks[0].data !== 32'hDEAD_BEEF) begin
                miscompares++;
                $display("FAIL single_rdata got %h exp deadbeef", acks[0].data);
            end
        end
    endtask

    task automatic test_tie();
        int c0, nre, nwe;
        do_reset(0);
        q0.push_back('{32'h7FFF_FFFC, 32'h0000_0011, 1'b1, 2'b11});
        q1.push_back('{32'hFFFF_0004, 32'h0, 1'b0, 2'b11});
        c0 = cyc;
        run(12);
        nre = 0; nwe = 0;
        foreach (strb[i]) if (strb[i].we) nwe++; else nre++;
        vectors++;
        if (nre !== 1 || nwe !== 1) begin
            miscompares++;
            $display("FAIL tie_pulses got re %0d we %0d exp 1 1", nre, nwe);
        end
        vectors++;
        if (acks.size() !== 2) begin miscompares++; $display("FAIL tie_ack_count got %0d exp 2", acks.size()); end
        if (acks.size() == 2 && strb.size() == 2) begin
            vectors++;
            if (acks[0].m !== 1'b0 || acks[0].cyc !== c0 + 2 || acks[0].data !== 32'h0) begin
                miscompares++;
                $display("FAIL tie_first got m%0d at %0d data %h exp m0 at 2 data 0",
                         acks[0].m, acks[0].cyc - c0, acks[0].data);
            end
            vectors++;
            if (strb[0].addr !== 32'h7FFF_FFFC || strb[0].data !== 32'h11 || strb[0].we !== 1'b1) begin
                miscompares++;
                $display("FAIL tie_write got addr %h data %h we %b exp 7ffffffc 11 1",
                         strb[0].addr, strb[0].data, strb[0].we);
            end
            vectors++;
            if (strb[1].cyc !== acks[0].cyc + 1 || strb[1].addr !== 32'hFFFF_0004) begin
                miscompares++;
                $display("FAIL tie_m1_strobe got cyc %0d addr %h exp cyc %0d addr ffff0004",
                         strb[1].cyc, strb[1].addr, acks[0].cyc + 1);
            end
            vectors++;
            if (acks[1].m !== 1'b1 || acks[1].data !== mem_model(32'hFFFF_0004)) begin
                miscompares++;
                $display("FAIL tie_second got m%0d data %h exp m1 data %h",
                         acks[1].m, acks[1].data, mem_model(32'hFFFF_0004));
            end
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        do_reset(0);
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{$urandom, $urandom, 1'($urandom_range(0, 1)), 2'b11});
            q1.push_back('{$urandom, $urandom, 1'($urandom_range(0, 1)), 2'b11});
        end
        c0 = cyc;
        run(30);
        vectors++;
        if (acks.size() !== 8) begin miscompares++; $display("FAIL b2b_ack_count got %0d exp 8", acks.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < acks.size()) begin
                vectors++;
                if (acks[i].m !== 1'(i % 2) || acks[i].cyc !== c0 + 2 + 2 * i) begin
                    miscompares++;
                    $display("FAIL b2b_ack%0d got m%0d at %0d exp m%0d at %0d",
                             i, acks[i].m, acks[i].cyc - c0, i % 2, 2 + 2 * i);
                end
            end
            if (i < strb.size()) begin
                vectors++;
                if (strb[i].m !== 1'(i % 2)) begin
                    miscompares++;
                    $display("FAIL b2b_grant%0d got %0d exp %0d", i, strb[i].m, i % 2);
                end
            end
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] a;
        logic        exp_re;
        do_reset(1);
        a = 32'h2000_0100;
        m1_addr = a; m1_wdata = 32'h0; m1_we = 1'b0; m1_size = 2'b11; m1_req = 1'b1;
        @(negedge clock);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            if (k <= 4) begin
                exp_re = (k == 4);
                vectors++;
                if (b_mem_addr !== a || b_mem_re !== exp_re || b_mem_we !== 1'b0 || b_m1_ack !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ws3_cycle%0d got addr %h re %b we %b ack %b exp addr %h re %b we 0 ack 0",
                             k, b_mem_addr, b_mem_re, b_mem_we, b_m1_ack, a, exp_re);
                end
            end else begin
                vectors++;
                if (b_m1_ack !== 1'b1 || b_m1_rdata !== mem_model(a) || b_m0_ack !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ws3_ack got ack %b rdata %h exp ack 1 rdata %h",
                             b_m1_ack, b_m1_rdata, mem_model(a));
                end
            end
        end
        m1_req = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid();
        int c0;
        do_reset(1);
        q1.push_back('{32'h3000_0008, 32'h0, 1'b0, 2'b11});
        run(2);
        #2;
        reset = 1'b0;
        q0.delete(); q1.delete();
        present();
        #1;
        vectors++;
        if ({b_m0_ack, b_m1_ack, b_mem_re, b_mem_we, b_busy, b_grant, b_mem_addr} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs got re %b we %b busy %b grant %b addr %h exp all 0",
                     b_mem_re, b_mem_we, b_busy, b_grant, b_mem_addr);
        end
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        run(6);
        vectors++;
        if (strb.size() !== 0 || acks.size() !== 0) begin
            miscompares++;
            $display("FAIL midreset_activity got strobes %0d acks %0d exp 0 0", strb.size(), acks.size());
        end
        q0.push_back('{32'h3000_0010, 32'h0, 1'b0, 2'b11});
        q1.push_back('{32'h3000_0014, 32'h0, 1'b0, 2'b11});
        c0 = cyc;
        run(20);
        vectors++;
        if (acks.size() !== 2) begin miscompares++; $display("FAIL midreset_ack_count got %0d exp 2", acks.size()); end
        if (acks.size() == 2) begin
            vectors++;
            if (acks[0].m !== 1'b0 || acks[0].cyc !== c0 + 5 || acks[0].data !== mem_model(32'h3000_0010)) begin
                miscompares++;
                $display("FAIL midreset_first got m%0d at %0d data %h exp m0 at 5 data %h",
                         acks[0].m, acks[0].cyc - c0, acks[0].data, mem_model(32'h3000_0010));
            end
            vectors++;
            if (acks[1].m !== 1'b1 || acks[1].cyc !== c0 + 10 || acks[1].data !== mem_model(32'h3000_0014)) begin
                miscompares++;
                $display("FAIL midreset_second got m%0d at %0d data %h exp m1 at 10 data %h",
                         acks[1].m, acks[1].cyc - c0, acks[1].data, mem_model(32'h3000_0014));
            end
        end
    endtask

    task automatic test_random_traffic();
        for (int iter = 0; iter < 6; iter++) begin
            bit   inst;
            int   ws, n0, n1, total, c0, t, i0, i1;
            logic last, m;
            txn_t e0[$], e1[$], exp_t[$];
            int   exp_cyc[$];
            logic exp_m[$];
            logic [31:0] exp_data;
            txn_t tx;
            inst = 1'(iter % 2);
            ws = inst ? 3 : 0;
            do_reset(inst);
            n0 = $urandom_range(0, 5);
            n1 = $urandom_range(1, 5);
            for (int i = 0; i < n0; i++) begin
                tx = '{$urandom, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
                q0.push_back(tx); e0.push_back(tx);
            end
            for (int i = 0; i < n1; i++) begin
                tx = '{$urandom, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
                q1.push_back(tx); e1.push_back(tx);
            end
            total = n0 + n1;
            // round-robin order and latency from the transaction rules
            c0 = cyc; last = 1'b1; i0 = 0; i1 = 0; t = 0;
            for (int n = 0; n < total; n++) begin
                if (i0 < n0 && i1 < n1) m = ~last;
                else m = (i0 < n0) ? 1'b0 : 1'b1;
                if (n == 0) t = c0 + 2 + ws;
                else t = t + ((m != last) ? 2 + ws : 3 + ws);
                exp_m.push_back(m);
                exp_cyc.push_back(t);
                if (m) begin exp_t.push_back(e1[i1]); i1++; end
                else   begin exp_t.push_back(e0[i0]); i0++; end
                last = m;
            end
            run(total * (3 + ws) + 6);
            vectors++;
            if (acks.size() !== total || strb.size() !== total) begin
                miscompares++;
                $display("FAIL rand%0d_counts got acks %0d strobes %0d exp %0d",
                         iter, acks.size(), strb.size(), total);
            end
            for (int n = 0; n < total; n++) begin
                exp_data = exp_t[n].we ? 32'h0 : mem_model(exp_t[n].addr);
                if (n < acks.size()) begin
                    vectors++;
                    if (acks[n].m !== exp_m[n] || acks[n].cyc !== exp_cyc[n] || acks[n].data !== exp_data) begin
                        miscompares++;
                        $display("FAIL rand%0d_ack%0d got m%0d at %0d data %h exp m%0d at %0d data %h",
                                 iter, n, acks[n].m, acks[n].cyc - c0, acks[n].data,
                                 exp_m[n], exp_cyc[n] - c0, exp_data);
                    end
                end
                if (n < strb.size()) begin
                    vectors++;
                    if (strb[n].addr !== exp_t[n].addr || strb[n].we !== exp_t[n].we ||
                        strb[n].cyc !== exp_cyc[n] - 1 || strb[n].m !== exp_m[n] ||
                        (exp_t[n].we && strb[n].data !== exp_t[n].wdata)) begin
                        miscompares++;
                        $display("FAIL rand%0d_strobe%0d got addr %h we %b data %h at %0d exp addr %h we %b data %h at %0d",
                                 iter, n, strb[n].addr, strb[n].we, strb[n].data, strb[n].cyc - c0,
                                 exp_t[n].addr, exp_t[n].we, exp_t[n].wdata, exp_cyc[n] - 1 - c0);
                    end
                end
            end
        end
    endtask

`ifdef DMEM_ARB_LOCK_EN
    task automatic test_lock();
        int c0;
        do_reset(0);
        for (int i = 0; i < 3; i++) q1.push_back('{32'h4000_0000 + 32'(4 * i), 32'(i), 1'b1, 2'b11});
        m1_lock = 1'b1;
        c0 = cyc;
        run(1);
        q0.push_back('{32'h4000_0100, 32'h0, 1'b0, 2'b11});
        run(20);
        vectors++;
        if (acks.size() !== 4) begin miscompares++; $display("FAIL lock_ack_count got %0d exp 4", acks.size()); end
        if (acks.size() == 4) begin
            vectors++;
            if (acks[0].m !== 1'b1 || acks[1].m !== 1'b1 || acks[2].m !== 1'b1 || acks[3].m !== 1'b0) begin
                miscompares++;
                $display("FAIL lock_order got %0d%0d%0d%0d exp 1110", acks[0].m, acks[1].m, acks[2].m, acks[3].m);
            end
            vectors++;
            if (acks[3].cyc !== c0 + 11) begin
                miscompares++;
                $display("FAIL lock_m0_ack got %0d exp 11", acks[3].cyc - c0);
            end
        end
    endtask
`endif

    initial begin
        m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        m0_size = '0; m1_size = '0;
`ifdef DMEM_ARB_LOCK_EN
        m0_lock = 1'b0; m1_lock = 1'b0;
`endif
        test_reset();
        test_single_read();
        test_tie();
        test_back_to_back();
        test_wait_states();
        test_reset_mid();
        test_random_traffic();
`ifdef DMEM_ARB_LOCK_EN
        test_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
